// File: rtl/ahbl_arbiter_rr.sv
// AHB-Lite multi-master arbiter: fixed-high, fixed-low or round-robin address-phase
// selection with burst/lock hold, data-phase owner tracking and a lock-duration watchdog.
module ahbl_arbiter_rr #(
    parameter  int MM         = 4,
    parameter  int MODE       = 2,
    parameter  int PARK       = 0,
    parameter  int LOCK_LIMIT = 64,
    localparam int MW         = $clog2(MM)
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [MM-1:0][1:0]   HTRANS,
    input  logic [MM-1:0]        HMASTLOCK,
    input  logic [MM-1:0]        HREADY,
    input  logic [MM-1:0]        MASTER_EN,
    output logic [MM-1:0]        ARB_SEL,
    output logic [MW-1:0]        MASTER_SEL,
    output logic [MM-1:0]        ARB_SEL_PREV,
    output logic [MW-1:0]        MASTER_SEL_PREV,
    output logic [MW-1:0]        RR_PTR,
    output logic                 LOCK_TIMEOUT
);

    localparam logic [1:0]    TR_IDLE     = 2'd0;
    localparam logic [1:0]    TR_BUSY     = 2'd1;
    localparam logic [1:0]    TR_NONSEQ   = 2'd2;
    localparam logic [1:0]    TR_SEQ      = 2'd3;
    localparam logic [1:0]    MODE_SEL    = 2'(MODE);
    localparam logic [MW-1:0] PARK_SEL    = MW'(PARK);
    localparam logic [MW-1:0] LAST_SEL    = MW'(MM - 1);
    localparam logic [MW:0]   MM_W        = (MW + 1)'(MM);
    localparam logic [MM-1:0] ONE_HOT0    = {{(MM-1){1'b0}}, 1'b1};
    localparam logic [MM-1:0] PARK_ONEHOT = ONE_HOT0 << PARK;
    localparam logic [15:0]   LIMIT_CNT   = 16'(LOCK_LIMIT);

    logic [MW-1:0] prev_r;
    logic [MM-1:0] arb_prev_r;
    logic [MW-1:0] rr_ptr_r;
    logic [15:0]   lock_cnt_r;
    logic          timeout_r;

    logic          hold_s;
    logic          lock_s;
    logic [MM-1:0] req_s;
    logic          any_req_s;
    logic [MW-1:0] sel_s;
    logic [MW:0]   rr_idx_s;
    logic [MM-1:0] arb_s;
    logic          rr_upd_s;
    logic [MW-1:0] rr_next_s;
    logic [15:0]   lock_cnt_nxt_s;

    // Hold detection on the data-phase owner and per-master request qualification
    always_comb begin
        lock_s    = HMASTLOCK[prev_r];
        hold_s    = lock_s || (HTRANS[prev_r] == TR_BUSY) || (HTRANS[prev_r] == TR_SEQ);
        req_s     = '0;
        for (int i = 0; i < MM; i++) begin
            req_s[i] = (HTRANS[i] != TR_IDLE) && MASTER_EN[i];
        end
        any_req_s = |req_s;
    end

    // Address-phase owner selection; later loop iterations take priority
    always_comb begin
        sel_s    = PARK_SEL;
        rr_idx_s = '0;
        if (hold_s) begin
            sel_s = prev_r;
        end else if (!any_req_s) begin
            sel_s = PARK_SEL;
        end else begin
            case (MODE_SEL)
                2'd0: begin
                    for (int i = 0; i < MM; i++) begin
                        sel_s = req_s[i] ? MW'(i) : sel_s;
                    end
                end
                2'd1: begin
                    for (int i = MM - 1; i >= 0; i--) begin
                        sel_s = req_s[i] ? MW'(i) : sel_s;
                    end
                end
                default: begin
                    // Walk the offsets backwards so the nearest requester after RR_PTR wins
                    for (int k = MM - 1; k >= 0; k--) begin
                        rr_idx_s = {1'b0, rr_ptr_r} + (MW + 1)'(k);
                        rr_idx_s = (rr_idx_s >= MM_W) ? (rr_idx_s - MM_W) : rr_idx_s;
                        sel_s    = req_s[rr_idx_s[MW-1:0]] ? rr_idx_s[MW-1:0] : sel_s;
                    end
                end
            endcase
        end
        arb_s = ONE_HOT0 << sel_s;
    end

    // Round-robin pointer advance and lock watchdog next-state
    always_comb begin
        rr_upd_s  = (MODE_SEL == 2'd2) && HREADY[prev_r] && !hold_s &&
                    req_s[sel_s] && (HTRANS[sel_s] == TR_NONSEQ);
        rr_next_s = (sel_s == LAST_SEL) ? {MW{1'b0}} : (sel_s + MW'(1'b1));
        if (LIMIT_CNT == 16'd0) begin
            lock_cnt_nxt_s = 16'd0;
        end else if (!lock_s) begin
            lock_cnt_nxt_s = 16'd0;
        end else if (lock_cnt_r == LIMIT_CNT) begin
            lock_cnt_nxt_s = lock_cnt_r;
        end else begin
            lock_cnt_nxt_s = lock_cnt_r + 16'd1;
        end
    end

    // Data-phase owner, round-robin pointer and watchdog state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prev_r     <= PARK_SEL;
            arb_prev_r <= PARK_ONEHOT;
            rr_ptr_r   <= '0;
            lock_cnt_r <= 16'd0;
            timeout_r  <= 1'b0;
        end else begin
            if (HREADY[prev_r]) begin
                prev_r     <= sel_s;
                arb_prev_r <= arb_s;
            end else begin
                prev_r     <= prev_r;
                arb_prev_r <= arb_prev_r;
            end
            if (rr_upd_s) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            lock_cnt_r <= lock_cnt_nxt_s;
            timeout_r  <= (LIMIT_CNT != 16'd0) && (lock_cnt_nxt_s == LIMIT_CNT);
        end
    end

    assign ARB_SEL         = arb_s;
    assign MASTER_SEL      = sel_s;
    assign ARB_SEL_PREV    = arb_prev_r;
    assign MASTER_SEL_PREV = prev_r;
    assign RR_PTR          = rr_ptr_r;
    assign LOCK_TIMEOUT    = timeout_r;

endmodule

// File: tb/tb_ahbl_arbiter_rr.sv
// Directed bench for ahbl_arbiter_rr: three instances (round-robin, fixed-high,
// fixed-low with park 3) share one set of master-side inputs.
module tb_ahbl_arbiter_rr;

    logic            HCLK;
    logic            HRESETn;
    logic [3:0][1:0] HTRANS;
    logic [3:0]      HMASTLOCK;
    logic [3:0]      HREADY;
    logic [3:0]      MASTER_EN;

    logic [3:0] rr_arb, rr_arbp, hi_arb, hi_arbp, lo_arb, lo_arbp;
    logic [1:0] rr_sel, rr_selp, rr_ptr, hi_sel, hi_selp, hi_ptr, lo_sel, lo_selp, lo_ptr;
    logic       rr_to, hi_to, lo_to;

    int total = 0;
    int bad   = 0;

    ahbl_arbiter_rr #(.MM(4), .MODE(2), .PARK(0), .LOCK_LIMIT(4)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .MASTER_EN(MASTER_EN), .ARB_SEL(rr_arb), .MASTER_SEL(rr_sel),
        .ARB_SEL_PREV(rr_arbp), .MASTER_SEL_PREV(rr_selp), .RR_PTR(rr_ptr),
        .LOCK_TIMEOUT(rr_to));

    ahbl_arbiter_rr #(.MM(4), .MODE(0), .PARK(0), .LOCK_LIMIT(0)) u_hi (
        .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .MASTER_EN(MASTER_EN), .ARB_SEL(hi_arb), .MASTER_SEL(hi_sel),
        .ARB_SEL_PREV(hi_arbp), .MASTER_SEL_PREV(hi_selp), .RR_PTR(hi_ptr),
        .LOCK_TIMEOUT(hi_to));

    ahbl_arbiter_rr #(.MM(4), .MODE(1), .PARK(3), .LOCK_LIMIT(64)) u_lo (
        .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .MASTER_EN(MASTER_EN), .ARB_SEL(lo_arb), .MASTER_SEL(lo_sel),
        .ARB_SEL_PREV(lo_arbp), .MASTER_SEL_PREV(lo_selp), .RR_PTR(lo_ptr),
        .LOCK_TIMEOUT(lo_to));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        HTRANS    = '0;
        HMASTLOCK = 4'b0000;
        HREADY    = 4'b1111;
        MASTER_EN = 4'b1111;
    endtask

    task automatic do_reset();
        idle_inputs();
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
    endtask

    initial begin
        idle_inputs();
        HRESETn = 1'b0;
        #12;
        chk("rst_sel",     32'(rr_sel),  32'd0);
        chk("rst_arb",     32'(rr_arb),  32'h1);
        chk("rst_prev",    32'(rr_selp), 32'd0);
        chk("rst_ptr",     32'(rr_ptr),  32'd0);
        chk("rst_to",      32'(rr_to),   32'd0);
        chk("rst_lo_prev", 32'(lo_selp), 32'd3);
        chk("rst_lo_arbp", 32'(lo_arbp), 32'h8);

        // Fixed-high: burst continuation holds the grant
        do_reset();
        HTRANS[1] = 2'd2;
        HTRANS[3] = 2'd2;
        #1;
        chk("hi_pick3", 32'(hi_sel), 32'd3);
        tick();
        HTRANS[1] = 2'd0;
        HTRANS[2] = 2'd2;
        HTRANS[3] = 2'd3;
        #1;
        chk("hi_hold_a", 32'(hi_sel), 32'd3);
        tick();
        chk("hi_hold_b", 32'(hi_sel), 32'd3);
        HTRANS[3] = 2'd0;
        #1;
        chk("hi_next2", 32'(hi_sel), 32'd2);
        chk("hi_arb2",  32'(hi_arb), 32'h4);
        tick();
        chk("hi_prev2", 32'(hi_selp), 32'd2);

        // Round-robin: back-to-back NONSEQ from everybody
        do_reset();
        HTRANS = {2'd2, 2'd2, 2'd2, 2'd2};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_grant", 32'(rr_sel), 32'(i % 4));
            tick();
            chk("rr_ptr",  32'(rr_ptr),  32'((i + 1) % 4));
            chk("rr_prev", 32'(rr_selp), 32'(i % 4));
        end

        // Round-robin: wait states freeze owner and pointer
        HTRANS = {2'd0, 2'd0, 2'd2, 2'd0};
        #1;
        chk("ws_grant1", 32'(rr_sel), 32'd1);
        tick();
        HREADY    = 4'b1101;
        HTRANS[2] = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_prev_frozen", 32'(rr_selp), 32'd1);
            chk("ws_ptr_frozen",  32'(rr_ptr),  32'd2);
        end
        HREADY = 4'b1111;
        tick();
        chk("ws_prev_adv", 32'(rr_selp), 32'd2);
        chk("ws_ptr_adv",  32'(rr_ptr),  32'd3);

        // Lock: master 2 pinned despite being disabled; hold beats pointer update
        HTRANS    = {2'd2, 2'd2, 2'd0, 2'd0};
        HMASTLOCK = 4'b0100;
        MASTER_EN = 4'b1011;
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk("lk_grant", 32'(rr_sel), 32'd2);
            tick();
            chk("lk_to",   32'(rr_to),  32'(c >= 4));
            chk("lk_ptr",  32'(rr_ptr), 32'd3);
        end
        HMASTLOCK = 4'b0000;
        HTRANS[2] = 2'd0;
        #1;
        chk("lk_to_still", 32'(rr_to),  32'd1);
        chk("lk_release",  32'(rr_sel), 32'd3);
        tick();
        chk("lk_to_fall",  32'(rr_to),   32'd0);
        chk("lk_prev3",    32'(rr_selp), 32'd3);
        chk("lk_ptr0",     32'(rr_ptr),  32'd0);

        // Asynchronous reset in the middle of a locked burst
        HMASTLOCK = 4'b1000;
        tick();
        tick();
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_prev", 32'(rr_selp), 32'd0);
        chk("mid_rst_arbp", 32'(rr_arbp), 32'h1);
        chk("mid_rst_ptr",  32'(rr_ptr),  32'd0);
        chk("mid_rst_to",   32'(rr_to),   32'd0);

        // Fixed-low with masking and park
        do_reset();
        MASTER_EN = 4'b1110;
        HTRANS    = {2'd0, 2'd2, 2'd0, 2'd2};
        #1;
        chk("lo_pick2", 32'(lo_sel), 32'd2);
        chk("lo_arb2",  32'(lo_arb), 32'h4);
        MASTER_EN = 4'b0000;
        #1;
        chk("lo_park3", 32'(lo_sel), 32'd3);
        chk("lo_arb3",  32'(lo_arb), 32'h8);
        chk("hi_park0", 32'(hi_sel), 32'd0);
        tick();
        chk("lo_prev3", 32'(lo_selp), 32'd3);
        chk("lo_ptr0",  32'(lo_ptr),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
